// File: rtl/t_sram_server_pkg.sv
// Shared word-format definitions for the T-storage protocol (server and data processor).
// A stored element is {t[1:0], v, f}; element 0 sits at the MSB end of the payload.
package t_sram_server_pkg;

  localparam int VEF_BIT        = 16;
  localparam int VF_W           = VEF_BIT - 1;
  localparam int BIT_P_GROUP    = 2 + 2 * VF_W;
  localparam int T_PER_WORD     = 4;
  localparam int K_W            = $clog2(T_PER_WORD);
  localparam int HEADER_BIT     = 4;
  localparam int CNT_W          = HEADER_BIT - 1;
  localparam int PAYLOAD_W      = T_PER_WORD * BIT_P_GROUP;
  localparam int SRAM_WORD      = HEADER_BIT + PAYLOAD_W;
  localparam int MEM_W          = CNT_W + PAYLOAD_W;
  localparam int DEPTH_LOG      = 7;
  localparam int MAX_T_SIZE_LOG = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2
  } state_e;

  // Payload with only the t field of element `slot` set; v and f stay zero.
  function automatic logic [PAYLOAD_W-1:0] place_t(input logic [1:0] t, input logic [K_W-1:0] slot);
    return {t, {(PAYLOAD_W-2){1'b0}}} >> (32'(slot) * 32'(BIT_P_GROUP));
  endfunction

endpackage

// File: rtl/t_sram_server_word_mem.sv
// Word store: one write port, one registered read port; read data holds when not enabled.
module t_word_mem
  import t_sram_server_pkg::*;
#(
  parameter int ADDR_W = DEPTH_LOG,
  parameter int DATA_W = MEM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Only the output register is reset so the array itself can map to block RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/t_sram_server.sv
// Long-T SRAM responder: packs the host T stream into tagged words, serves them to the
// processor one per request and stores its write-backs in the same circular order.
module t_sram_server
  import t_sram_server_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_load_valid,
  input  logic [1:0]                i_load_t,
  input  logic                      i_load_last,
  output logic                      o_load_ready,
  output logic [MAX_T_SIZE_LOG-1:0] o_T_size,
  input  logic                      i_sram_request,
  output logic [SRAM_WORD-1:0]      o_request_data,
  input  logic                      i_sram_send,
  input  logic [SRAM_WORD-1:0]      i_send_data,
  input  logic                      i_sram_init,
  output logic                      o_overflow
);

  localparam logic [DEPTH_LOG:0]        FULL_OCC = {1'b1, {DEPTH_LOG{1'b0}}};
  localparam logic [K_W-1:0]            K_LAST   = K_W'(T_PER_WORD - 1);
  localparam logic [MAX_T_SIZE_LOG-1:0] T_STEP   = MAX_T_SIZE_LOG'(T_PER_WORD);

  state_e                    r_state, w_state_next;
  logic [DEPTH_LOG-1:0]      r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG:0]        r_occ;
  logic [K_W-1:0]            r_pack_k;
  logic [PAYLOAD_W-1:0]      r_pack;
  logic [MAX_T_SIZE_LOG-1:0] r_load_cnt, r_t_size, r_row_pos;
  logic                      r_served, r_overflow;

  logic                 w_full, w_loading, w_load_acc, w_word_end;
  logic                 w_serve, w_send, w_send_store, w_row_end, w_wr_en;
  logic [PAYLOAD_W-1:0] w_pack_next;
  logic [CNT_W-1:0]     w_load_cnt, w_send_cnt;
  logic [MEM_W-1:0]     w_wr_data, w_rd_data;
  logic                 w_unused_hdr;

  assign w_full       = (r_occ == FULL_OCC);
  assign w_loading    = (r_state != ST_SERVE);
  assign w_load_acc   = i_load_valid && w_loading && !w_full && !i_sram_init;
  assign w_pack_next  = r_pack | place_t(i_load_t, r_pack_k);
  assign w_word_end   = w_load_acc && (i_load_last || r_pack_k == K_LAST);
  assign w_load_cnt   = (i_load_last && r_pack_k != K_LAST) ? CNT_W'(r_pack_k) + 1'b1 : '0;

  // r_served blocks back-to-back serves: the processor's request lingers one cycle after delivery.
  assign w_serve      = (r_state == ST_SERVE) && i_sram_request && (r_occ != '0) && !r_served && !i_sram_init;
  assign w_send       = (r_state == ST_SERVE) && i_sram_send && !i_sram_init;
  assign w_send_store = w_send && !w_full;
  assign w_row_end    = ({1'b0, r_row_pos} + {1'b0, T_STEP}) >= {1'b0, r_t_size};
  assign w_send_cnt   = w_row_end ? CNT_W'(r_t_size[K_W-1:0]) : '0;

  assign w_wr_en      = w_word_end || w_send_store;
  assign w_wr_data    = w_loading ? {w_load_cnt, w_pack_next}
                                  : {w_send_cnt, i_send_data[PAYLOAD_W-1:0]};
  assign w_unused_hdr = ^i_send_data[SRAM_WORD-1:PAYLOAD_W];

  t_word_mem #(
    .ADDR_W (DEPTH_LOG),
    .DATA_W (MEM_W)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_serve),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_load_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_load_ready = !w_full;
        if (w_load_acc) w_state_next = i_load_last ? ST_SERVE : ST_LOAD;
      end
      ST_LOAD: begin
        o_load_ready = !w_full;
        if (w_load_acc && i_load_last) w_state_next = ST_SERVE;
      end
      ST_SERVE: w_state_next = ST_SERVE;
      default:  w_state_next = ST_IDLE;
    endcase
    if (i_sram_init) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_pack_k   <= '0;
      r_pack     <= '0;
      r_load_cnt <= '0;
      r_t_size   <= '0;
      r_row_pos  <= '0;
      r_served   <= 1'b0;
      r_overflow <= 1'b0;
    end else if (i_sram_init) begin
      // T size survives init so the processor can still read it after the job ends.
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_pack_k   <= '0;
      r_pack     <= '0;
      r_load_cnt <= '0;
      r_row_pos  <= '0;
      r_served   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_served <= w_serve;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_serve) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr_en && !w_serve)      r_occ <= r_occ + 1'b1;
      else if (!w_wr_en && w_serve) r_occ <= r_occ - 1'b1;

      if (w_load_acc) begin
        if (w_word_end) begin
          r_pack   <= '0;
          r_pack_k <= '0;
        end else begin
          r_pack   <= w_pack_next;
          r_pack_k <= r_pack_k + 1'b1;
        end
        if (i_load_last) begin
          r_t_size   <= r_load_cnt + 1'b1;
          r_load_cnt <= '0;
        end else begin
          r_load_cnt <= r_load_cnt + 1'b1;
        end
      end

      if (w_send) begin
        r_row_pos <= w_row_end ? '0 : r_row_pos + T_STEP;
        if (w_full) r_overflow <= 1'b1;
      end
    end
  end

  assign o_request_data = {r_served, w_rd_data};
  assign o_T_size       = r_t_size;
  assign o_overflow     = r_overflow;

endmodule
